// File: rtl/bcd_seg_pkg.sv
// Segment constants and the active-low hex decode shared by the seven-segment scan driver.
package bcd_seg_pkg;

    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_DASH  = 7'h3F;

    // Non-BCD nibbles render as a dash so corrupt input is visible rather than misleading.
    function automatic logic [6:0] bcd_to_seg(input logic [3:0] nibble);
        logic [6:0] s;
        case (nibble)
            4'd0:    s = SEG_0;
            4'd1:    s = SEG_1;
            4'd2:    s = SEG_2;
            4'd3:    s = SEG_3;
            4'd4:    s = SEG_4;
            4'd5:    s = SEG_5;
            4'd6:    s = SEG_6;
            4'd7:    s = SEG_7;
            4'd8:    s = SEG_8;
            4'd9:    s = SEG_9;
            default: s = SEG_DASH;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/seg7_decode.sv
// Nibble plus blank request to an active-low {g,f,e,d,c,b,a} pattern.
module seg7_decode
    import bcd_seg_pkg::*;
(
    input  logic [3:0] nibble,
    input  logic       blank,
    output logic [6:0] seg
);

    assign seg = blank ? SEG_BLANK : bcd_to_seg(nibble);

endmodule

// File: rtl/bcd_sevenseg_scan.sv
// Four-digit common-anode scan driver; the shown word is swapped in only at frame
// boundaries so a frame never mixes two values.
module bcd_sevenseg_scan
    import bcd_seg_pkg::*;
#(
    parameter int DIV      = 50000,
    parameter bit BLANK_LZ = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] bcd_in,
    input  logic        load,
    output logic [6:0]  seg,
    output logic [3:0]  an,
    output logic        frame_done
);

    localparam int PW = $clog2(DIV);
    localparam logic [PW-1:0] PRE_MAX = PW'(DIV - 1);

    logic [PW-1:0] pre;
    logic [1:0]    idx;
    logic [1:0]    idx_next;
    logic [15:0]   pending;
    logic [15:0]   shadow;
    logic [15:0]   src;
    logic          tick;
    logic          boundary;
    logic [3:0]    nibble;
    logic          upper_zero;
    logic [6:0]    seg_next;

    assign tick     = (pre == PRE_MAX);
    assign idx_next = idx + 2'd1;
    assign boundary = tick && (idx == 2'd3);
    // At a boundary the new frame's first digit must already come from the word being latched.
    assign src      = boundary ? pending : shadow;

    always_comb begin
        nibble     = src[3:0];
        upper_zero = 1'b0;
        case (idx_next)
            2'd0: begin nibble = src[3:0];   upper_zero = 1'b0;              end
            2'd1: begin nibble = src[7:4];   upper_zero = (src[15:4]  == '0); end
            2'd2: begin nibble = src[11:8];  upper_zero = (src[15:8]  == '0); end
            2'd3: begin nibble = src[15:12]; upper_zero = (src[15:12] == '0); end
            default: ;
        endcase
    end

    seg7_decode u_dec (
        .nibble (nibble),
        .blank  (BLANK_LZ && upper_zero),
        .seg    (seg_next)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre        <= '0;
            idx        <= 2'd3;
            pending    <= '0;
            shadow     <= '0;
            seg        <= SEG_BLANK;
            an         <= 4'hF;
            frame_done <= 1'b0;
        end else begin
            if (load)
                pending <= bcd_in;
            frame_done <= boundary;
            if (tick) begin
                pre <= '0;
                idx <= idx_next;
                an  <= ~(4'b0001 << idx_next);
                seg <= seg_next;
                if (boundary)
                    shadow <= pending;
            end else begin
                pre <= pre + PW'(1);
            end
        end
    end

endmodule

// File: tb/tb_bcd_sevenseg_scan.sv
// Scoreboard bench: a slot-level reference model predicts every digit change of two
// instances (blanking on and off); a negedge monitor pops and compares on each change.
module tb_bcd_sevenseg_scan;

    localparam int DIV   = 4;
    localparam int FRAME = 4 * DIV;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] bcd_in = '0;
    logic        load = 1'b0;
    logic [6:0]  seg1, seg0;
    logic [3:0]  an1, an0;
    logic        fd1, fd0;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [3:0] an;
        logic [6:0] s1;
        logic [6:0] s0;
        logic       fd;
    } exp_t;

    exp_t expq[$];

    bcd_sevenseg_scan #(.DIV(DIV), .BLANK_LZ(1'b1)) dut_lz (
        .clk(clk), .rst(rst), .bcd_in(bcd_in), .load(load),
        .seg(seg1), .an(an1), .frame_done(fd1)
    );

    bcd_sevenseg_scan #(.DIV(DIV), .BLANK_LZ(1'b0)) dut_nolz (
        .clk(clk), .rst(rst), .bcd_in(bcd_in), .load(load),
        .seg(seg0), .an(an0), .frame_done(fd0)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] ref_seg(input logic [15:0] val, input int d, input bit lz);
        logic [3:0]  nib;
        logic [15:0] upper;
        nib   = val[d*4 +: 4];
        upper = val >> (4 * d);
        if (lz && d > 0 && upper == 16'h0) return 7'h7F;
        case (nib)
            4'd0: return 7'h40;  4'd1: return 7'h79;
            4'd2: return 7'h24;  4'd3: return 7'h30;
            4'd4: return 7'h19;  4'd5: return 7'h12;
            4'd6: return 7'h02;  4'd7: return 7'h78;
            4'd8: return 7'h00;  4'd9: return 7'h10;
            default: return 7'h3F;
        endcase
    endfunction

    // Reference model: cycle count since reset decides the slot; the word shown for a
    // whole frame is whatever was last loaded before that frame's first slot edge.
    int          cyc = 0;
    logic [15:0] m_pend = '0;
    logic [15:0] m_shown = '0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            cyc    = 0;
            m_pend = '0;
            expq.delete();
        end else begin
            cyc++;
            if (cyc % DIV == 0) begin
                int d;
                exp_t e;
                d = (cyc / DIV - 1) % 4;
                if (d == 0) m_shown = m_pend;
                e.an = 4'hF;
                e.an[d] = 1'b0;
                e.s1 = ref_seg(m_shown, d, 1'b1);
                e.s0 = ref_seg(m_shown, d, 1'b0);
                e.fd = (d == 0);
                expq.push_back(e);
            end
            if (load) m_pend = bcd_in;
        end
    end

    logic [3:0] prev_an  = 4'hF;
    logic [6:0] prev_s1  = 7'h7F;
    logic [6:0] prev_s0  = 7'h7F;

    always @(negedge clk) begin
        if (rst) begin
            prev_an = 4'hF;
            prev_s1 = 7'h7F;
            prev_s0 = 7'h7F;
        end else begin
            total++;
            if (an1 != prev_an) begin
                if (expq.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_change t=%0t got an=%h seg=%h/%h fd=%b/%b, expected no change",
                             $time, an1, seg1, seg0, fd1, fd0);
                end else begin
                    exp_t e;
                    e = expq.pop_front();
                    if (an1 !== e.an || an0 !== e.an || seg1 !== e.s1 || seg0 !== e.s0 ||
                        fd1 !== e.fd || fd0 !== e.fd) begin
                        bad++;
                        $display("FAIL slot t=%0t got an=%h/%h seg=%h/%h fd=%b/%b expected an=%h seg=%h/%h fd=%b",
                                 $time, an1, an0, seg1, seg0, fd1, fd0, e.an, e.s1, e.s0, e.fd);
                    end
                end
            end else if (expq.size() != 0) begin
                bad++;
                $display("FAIL missed_slot t=%0t got an=%h expected an=%h", $time, an1, expq[0].an);
                void'(expq.pop_front());
            end else if (fd1 || fd0 || seg1 != prev_s1 || seg0 != prev_s0 || an0 != an1) begin
                bad++;
                $display("FAIL hold t=%0t got an=%h/%h seg=%h/%h fd=%b/%b expected seg=%h/%h fd=0",
                         $time, an1, an0, seg1, seg0, fd1, fd0, prev_s1, prev_s0);
            end
            prev_an = an1;
            prev_s1 = seg1;
            prev_s0 = seg0;
        end
    end

    task automatic check_dark(input string name);
        total++;
        if (seg1 !== 7'h7F || seg0 !== 7'h7F || an1 !== 4'hF || an0 !== 4'hF || fd1 !== 1'b0 || fd0 !== 1'b0) begin
            bad++;
            $display("FAIL %s got seg=%h/%h an=%h/%h fd=%b/%b expected seg=7f an=f fd=0",
                     name, seg1, seg0, an1, an0, fd1, fd0);
        end
    endtask

    task automatic load_now(input logic [15:0] v, input int hold);
        bcd_in = v;
        load   = 1'b1;
        repeat (hold) @(negedge clk);
        load   = 1'b0;
    endtask

    task automatic load_word(input logic [15:0] v, input int hold);
        @(negedge clk);
        load_now(v, hold);
    endtask

    task automatic wait_pos(input int p);
        int n = 0;
        @(negedge clk);
        while (cyc % FRAME != p && n < 4 * FRAME) begin
            @(negedge clk);
            n++;
        end
        if (cyc % FRAME != p) begin
            total++;
            bad++;
            $display("FAIL wait_pos got pos=%0d expected pos=%0d", cyc % FRAME, p);
        end
    endtask

    task automatic do_reset();
        #2 rst = 1'b1;
        #1 check_dark("reset_async");
        repeat (2) @(negedge clk);
        check_dark("reset_held");
        #2 rst = 1'b0;
    endtask

    function automatic logic [15:0] rand_word();
        logic [15:0] w;
        for (int k = 0; k < 4; k++) begin
            if ($urandom_range(0, 2) == 0) w[k*4 +: 4] = 4'h0;
            else if ($urandom_range(0, 7) == 0) w[k*4 +: 4] = 4'(10 + $urandom_range(0, 5));
            else w[k*4 +: 4] = 4'($urandom_range(0, 9));
        end
        return w;
    endfunction

    initial begin
        #1 rst = 1'b1;
        #1 check_dark("reset_state");
        @(negedge clk);
        #2 rst = 1'b0;

        // Untouched first frame shows a lone zero.
        repeat (2 * FRAME) @(negedge clk);

        load_word(16'h1234, 1);
        repeat (2 * FRAME) @(negedge clk);

        load_word(16'h0050, 1);
        repeat (2 * FRAME) @(negedge clk);

        // Load landing exactly on the boundary edge belongs to the following frame.
        wait_pos(8);
        load_now(16'h1111, 1);
        wait_pos(DIV - 1);
        load_now(16'h2222, 1);
        repeat (2 * FRAME) @(negedge clk);

        load_word(16'h0A07, 2);
        repeat (2 * FRAME) @(negedge clk);

        // Reset while digit 2 is lit.
        load_word(16'h9876, 1);
        repeat (FRAME) @(negedge clk);
        wait_pos(3 * DIV + 1);
        do_reset();
        repeat (2 * FRAME) @(negedge clk);

        for (int i = 0; i < 60; i++) begin
            int sel;
            sel = $urandom_range(0, 3);
            if (sel == 0) begin
                wait_pos(DIV - 1);
                load_now(rand_word(), 1);
            end else begin
                load_word(rand_word(), $urandom_range(1, 3));
            end
            repeat ($urandom_range(0, 2 * FRAME)) @(negedge clk);
        end

        repeat (2 * FRAME) @(negedge clk);
        total++;
        if (expq.size() != 0) begin
            bad++;
            $display("FAIL drain got pending=%0d expected 0", expq.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
